// File: rtl/muldiv_unit_if.sv
// Request/writeback bundle between the issuing core, muldiv_unit and the register-file write port.
// The core drives the request side (master); the unit answers with busy/done and one writeback.
interface muldiv_unit_if;
    logic        start;
    logic        kill;
    logic [2:0]  funct3;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [4:0]  rd_addr;
    logic        busy;
    logic        done;
    logic        wb_wrt_en;
    logic [4:0]  wb_wrt_addr;
    logic [31:0] wb_wrt_data;

    modport master (
        output start, kill, funct3, rs1_val, rs2_val, rd_addr,
        input  busy, done, wb_wrt_en, wb_wrt_addr, wb_wrt_data
    );

    modport slave (
        input  start, kill, funct3, rs1_val, rs2_val, rd_addr,
        output busy, done, wb_wrt_en, wb_wrt_addr, wb_wrt_data
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit feeding the register-file write port (radix-2, 32 steps).
// Define MULDIV_FAST_MUL_EN to resolve the four multiply ops in one cycle with a full 64-bit multiplier.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic          clk,
    input  logic          reset,
    muldiv_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2:0]          f3_q, f3_d;
    logic [4:0]          rd_q, rd_d;
    logic                negQ_q, negQ_d;
    logic                negR_q, negR_d;
    logic [XLEN-1:0]     op_q, op_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [4:0]          wbAddr_q, wbAddr_d;
    logic [XLEN-1:0]     wbData_q, wbData_d;

    logic                isDivIn, signA, signB, aNeg, bNeg;
    logic [XLEN-1:0]     aMag, bMag, specialRes;
    logic                divZero, divOvf;

    logic [2*XLEN-1:0]   accStep;
    logic [XLEN:0]       remSh;
    logic                remGeq;
    logic [XLEN:0]       addSum;

    // Undo the magnitude arithmetic: accumulator holds {hi,lo} product or {remainder,quotient}.
    function automatic logic [XLEN-1:0] finalResult(
        input logic [2:0]        f3,
        input logic [2*XLEN-1:0] acc,
        input logic              negQ,
        input logic              negR
    );
        logic [2*XLEN-1:0] prod;
        logic [XLEN-1:0]   quo;
        logic [XLEN-1:0]   rem;
        logic [XLEN-1:0]   res;
        prod = negQ ? -acc : acc;
        quo  = negQ ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem  = negR ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        if (f3[2]) begin
            res = f3[1] ? rem : quo;
        end else if (f3[1:0] == 2'b00) begin
            res = prod[XLEN-1:0];
        end else begin
            res = prod[2*XLEN-1:XLEN];
        end
        return res;
    endfunction

    always_comb begin
        isDivIn = bus.funct3[2];
        signA   = (bus.funct3 == 3'd1) || (bus.funct3 == 3'd2) ||
                  (bus.funct3 == 3'd4) || (bus.funct3 == 3'd6);
        signB   = (bus.funct3 == 3'd1) || (bus.funct3 == 3'd4) || (bus.funct3 == 3'd6);
        aNeg    = signA & bus.rs1_val[XLEN-1];
        bNeg    = signB & bus.rs2_val[XLEN-1];
        aMag    = aNeg ? -bus.rs1_val : bus.rs1_val;
        bMag    = bNeg ? -bus.rs2_val : bus.rs2_val;
        divZero = isDivIn && (bus.rs2_val == '0);
        divOvf  = isDivIn && !bus.funct3[0] &&
                  (bus.rs1_val == {1'b1, {(XLEN-1){1'b0}}}) && (bus.rs2_val == '1);
        if (divZero) begin
            specialRes = bus.funct3[1] ? bus.rs1_val : '1;
        end else begin
            specialRes = bus.funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        end
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] prodFast;
    assign prodFast = {{XLEN{1'b0}}, aMag} * {{XLEN{1'b0}}, bMag};
`endif

    // One radix-2 step: shift-add on {hi,multiplier} or restoring subtract on {rem,dividend}.
    always_comb begin
        accStep = acc_q;
        remSh   = '0;
        remGeq  = 1'b0;
        addSum  = '0;
        if (f3_q[2]) begin
            remSh  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
            remGeq = (remSh >= {1'b0, op_q});
            if (remGeq) begin
                accStep = {remSh[XLEN-1:0] - op_q, acc_q[XLEN-2:0], 1'b1};
            end else begin
                accStep = {remSh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
            end
        end else begin
            addSum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, op_q} : '0);
            accStep = {addSum, acc_q[XLEN-1:1]};
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        f3_d     = f3_q;
        rd_d     = rd_q;
        negQ_d   = negQ_q;
        negR_d   = negR_q;
        op_d     = op_q;
        acc_d    = acc_q;
        wbAddr_d = wbAddr_q;
        wbData_d = wbData_q;
        case (state_q)
            IDLE: begin
                if (bus.start && !bus.kill) begin
                    f3_d   = bus.funct3;
                    rd_d   = bus.rd_addr;
                    negQ_d = aNeg ^ bNeg;
                    negR_d = aNeg;
                    if (divZero || divOvf) begin
                        state_d  = DONE;
                        wbAddr_d = bus.rd_addr;
                        wbData_d = specialRes;
                    end
`ifdef MULDIV_FAST_MUL_EN
                    else if (!isDivIn) begin
                        state_d  = DONE;
                        wbAddr_d = bus.rd_addr;
                        wbData_d = finalResult(bus.funct3, prodFast, aNeg ^ bNeg, aNeg);
                    end
`endif
                    else begin
                        state_d = CALC;
                        cnt_d   = CNT_W'(XLEN);
                        op_d    = isDivIn ? bMag : aMag;
                        acc_d   = {{XLEN{1'b0}}, (isDivIn ? aMag : bMag)};
                    end
                end
            end
            CALC: begin
                if (bus.kill) begin
                    state_d = IDLE;
                end else begin
                    acc_d = accStep;
                    cnt_d = cnt_q - CNT_W'(1);
                    // Last step lands directly in the writeback registers.
                    if (cnt_q == CNT_W'(1)) begin
                        state_d  = DONE;
                        wbAddr_d = rd_q;
                        wbData_d = finalResult(f3_q, accStep, negQ_q, negR_q);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            f3_q     <= '0;
            rd_q     <= '0;
            negQ_q   <= 1'b0;
            negR_q   <= 1'b0;
            op_q     <= '0;
            acc_q    <= '0;
            wbAddr_q <= '0;
            wbData_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            f3_q     <= f3_d;
            rd_q     <= rd_d;
            negQ_q   <= negQ_d;
            negR_q   <= negR_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            wbAddr_q <= wbAddr_d;
            wbData_q <= wbData_d;
        end
    end

    // kill gates the completion strobes combinationally so an aborted DONE never writes.
    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = (state_q == DONE) && !bus.kill;
    assign bus.wb_wrt_en   = (state_q == DONE) && !bus.kill && (wbAddr_q != 5'd0);
    assign bus.wb_wrt_addr = wbAddr_q;
    assign bus.wb_wrt_data = wbData_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomised and directed bench for muldiv_unit against a plain-arithmetic RV32M reference.
// Expected latency follows MULDIV_FAST_MUL_EN when the bench is built with it.
module tb_muldiv_unit;

    logic clk = 1'b0;
    logic reset;
    int   checkCount = 0;
    int   failCount  = 0;

    always #5 clk = ~clk;

    muldiv_unit_if bus ();

    muldiv_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // RV32M semantics straight from the ISA rules using 64-bit host arithmetic.
    function automatic logic [31:0] refModel(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        logic [63:0] ua;
        logic [63:0] ub;
        logic [63:0] p;
        int          ia;
        int          ib;
        logic [31:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        ia = $signed(a);
        ib = $signed(b);
        r  = '0;
        case (f3)
            3'd0: begin p = ua * ub;                r = p[31:0];  end
            3'd1: begin p = sa * sb;                r = p[63:32]; end
            3'd2: begin p = sa * longint'(ub);      r = p[63:32]; end
            3'd3: begin p = ua * ub;                r = p[63:32]; end
            3'd4: begin
                if (b == 32'd0) r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
                else r = ia / ib;
            end
            3'd5: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
                else r = ia % ib;
            end
            default: r = (b == 32'd0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] pickOperand();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0:       v = 32'd0;
            1:       v = 32'h8000_0000;
            2:       v = 32'hFFFF_FFFF;
            3:       v = $urandom_range(0, 20);
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Issue one op, optionally pulse start mid-flight, then check timing and writeback.
    task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] rd, input bit pokeStart);
        logic [31:0] expData;
        bit          special;
        int          expLat;
        int          doneAt;
        int          busyCnt;
        logic        enAtDone;
        logic [4:0]  addrAtDone;
        logic [31:0] dataAtDone;
        expData = refModel(f3, a, b);
        special = f3[2] && ((b == 32'd0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
`ifdef MULDIV_FAST_MUL_EN
        special = special || !f3[2];
`endif
        expLat     = special ? 1 : 33;
        doneAt     = 0;
        busyCnt    = 0;
        enAtDone   = 1'b0;
        addrAtDone = '0;
        dataAtDone = '0;
        @(posedge clk);
        #1;
        bus.funct3  = f3;
        bus.rs1_val = a;
        bus.rs2_val = b;
        bus.rd_addr = rd;
        bus.start   = 1'b1;
        @(posedge clk);
        #1;
        bus.start   = 1'b0;
        bus.rs1_val = ~a;
        bus.rd_addr = rd + 5'd1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (bus.busy) busyCnt++;
            if (bus.done) begin
                doneAt     = c;
                enAtDone   = bus.wb_wrt_en;
                addrAtDone = bus.wb_wrt_addr;
                dataAtDone = bus.wb_wrt_data;
                break;
            end
            if (pokeStart && expLat > 10 && c == 5) bus.start = 1'b1;
            if (pokeStart && expLat > 10 && c == 8) bus.start = 1'b0;
        end
        checkOutput($sformatf("latency f3=%0d", f3), 64'(doneAt), 64'(expLat));
        checkOutput($sformatf("busyCycles f3=%0d", f3), 64'(busyCnt), 64'(expLat));
        checkOutput($sformatf("data f3=%0d a=%0h b=%0h", f3, a, b), 64'(dataAtDone), 64'(expData));
        checkOutput($sformatf("addr f3=%0d", f3), 64'(addrAtDone), 64'(rd));
        checkOutput($sformatf("wrtEn rd=%0d", rd), 64'(enAtDone), 64'(rd != 5'd0));
        @(negedge clk);
        checkOutput("donePulseWidth", 64'(bus.done), 64'd0);
        checkOutput("busyAfterDone", 64'(bus.busy), 64'd0);
        checkOutput("wbDataHold", 64'(bus.wb_wrt_data), 64'(expData));
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int sawDone;
        reset       = 1'b0;
        bus.start   = 1'b0;
        bus.kill    = 1'b0;
        bus.funct3  = '0;
        bus.rs1_val = '0;
        bus.rs2_val = '0;
        bus.rd_addr = '0;
        repeat (2) @(negedge clk);
        checkOutput("resetBusy", 64'(bus.busy), 64'd0);
        checkOutput("resetDone", 64'(bus.done), 64'd0);
        checkOutput("resetWrtEn", 64'(bus.wb_wrt_en), 64'd0);
        checkOutput("resetAddr", 64'(bus.wb_wrt_addr), 64'd0);
        checkOutput("resetData", 64'(bus.wb_wrt_data), 64'd0);
        reset = 1'b1;

        // Directed cases, the first with stray start pulses while busy.
        applyStimulus(3'd0, 32'd7,         32'hFFFF_FFFD, 5'd5,  1'b1);
        applyStimulus(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9,  1'b0);
        applyStimulus(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd10, 1'b0);
        applyStimulus(3'd2, 32'hFFFF_FFFF, 32'd2,         5'd11, 1'b0);
        applyStimulus(3'd4, 32'hFFFF_FFF9, 32'd2,         5'd12, 1'b1);
        applyStimulus(3'd6, 32'hFFFF_FFF9, 32'd2,         5'd13, 1'b0);
        applyStimulus(3'd5, 32'd100,       32'd7,         5'd14, 1'b0);
        applyStimulus(3'd7, 32'd100,       32'd7,         5'd15, 1'b0);
        applyStimulus(3'd4, 32'd5,         32'd0,         5'd16, 1'b0);
        applyStimulus(3'd7, 32'd5,         32'd0,         5'd17, 1'b0);
        applyStimulus(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 1'b0);
        applyStimulus(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd19, 1'b0);
        applyStimulus(3'd0, 32'd3,         32'd4,         5'd0,  1'b0);

        // kill during the tenth CALC cycle of a divide
        @(posedge clk);
        #1;
        bus.funct3  = 3'd5;
        bus.rs1_val = 32'd1000;
        bus.rs2_val = 32'd3;
        bus.rd_addr = 5'd7;
        bus.start   = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        bus.kill = 1'b1;
        checkOutput("killBusyBefore", 64'(bus.busy), 64'd1);
        @(posedge clk);
        #1;
        bus.kill = 1'b0;
        @(negedge clk);
        checkOutput("killBusyAfter", 64'(bus.busy), 64'd0);
        sawDone = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.done || bus.wb_wrt_en) sawDone++;
        end
        checkOutput("killNoWriteback", 64'(sawDone), 64'd0);
        applyStimulus(3'd5, 32'd1000, 32'd3, 5'd7, 1'b0);

        // start and kill together in IDLE: nothing accepted
        @(posedge clk);
        #1;
        bus.funct3 = 3'd0;
        bus.start  = 1'b1;
        bus.kill   = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.kill  = 1'b0;
        @(negedge clk);
        checkOutput("startKillIdle", 64'(bus.busy), 64'd0);

        // asynchronous reset in the middle of CALC
        @(posedge clk);
        #1;
        bus.funct3  = 3'd4;
        bus.rs1_val = 32'd123;
        bus.rs2_val = 32'd7;
        bus.rd_addr = 5'd3;
        bus.start   = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("midResetBusy", 64'(bus.busy), 64'd0);
        checkOutput("midResetDone", 64'(bus.done), 64'd0);
        checkOutput("midResetWrtEn", 64'(bus.wb_wrt_en), 64'd0);
        checkOutput("midResetAddr", 64'(bus.wb_wrt_addr), 64'd0);
        checkOutput("midResetData", 64'(bus.wb_wrt_data), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(3'd4, 32'd123, 32'd7, 5'd3, 1'b0);

        for (int n = 0; n < 40; n++) begin
            logic [2:0]  rf3;
            logic [31:0] ra;
            logic [31:0] rb;
            logic [4:0]  rrd;
            rf3 = 3'($urandom_range(0, 7));
            ra  = pickOperand();
            rb  = pickOperand();
            rrd = 5'($urandom_range(0, 31));
            applyStimulus(rf3, ra, rb, rrd, ($urandom_range(0, 3) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit that sits directly upstream of the register file write port.
- Accepts an M-extension op plus operand values, computes the result over multiple cycles, then presents one single-cycle write request (address, data, enable) for the register file.
- The core stalls on busy.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- CNT_W, 6, width of the iteration counter; must hold XLEN.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  op request; sampled only in IDLE.
- kill  input  1  abort the in-flight op; no writeback.
- funct3  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- rs1_val  input  32  operand A (multiplicand/dividend).
- rs2_val  input  32  operand B (multiplier/divisor).
- rd_addr  input  5  destination register.
- busy  output  1  high in CALC and DONE.
- done  output  1  one-cycle completion pulse.
- wb_wrt_en  output  1  register-file write enable.
- wb_wrt_addr  output  5  register-file write address.
- wb_wrt_data  output  32  register-file write data.

Behaviour:
- Reset (reset=0, async): state=IDLE; busy, done, wb_wrt_en = 0; wb_wrt_addr = 0; wb_wrt_data = 0; counter and internal registers cleared.
- State machine:
  - IDLE -> CALC on start=1, except the special cases below, which go IDLE -> DONE.
  - CALC -> DONE when the counter reaches 0.
  - DONE -> IDLE unconditionally.
- Capture: on the accepting edge, latch funct3, rd_addr, and operand magnitudes plus sign flags. Signedness per op: MULH signed x signed; MULHSU signed x unsigned; DIV/REM signed.
- CALC: one radix-2 step per cycle (shift-add for multiply, restoring shift-subtract for divide). Counter loads XLEN and decrements each CALC cycle.
- Result:
  - Multiply: 64-bit product, sign-corrected. MUL returns low 32 bits; MULH/MULHSU/MULHU return high 32 bits.
  - Divide: quotient truncates toward zero. Remainder takes the dividend's sign.
- Latency:
  - start high at edge 0 -> CALC at edges 1..32 -> done/wb_wrt_en high in the cycle after edge 33, for exactly one cycle.
  - Special cases: done in the cycle after edge 1.
- Special cases, resolved in IDLE without iterating:
  - Divide by zero: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> rs1_val.
  - Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF): DIV -> 0x80000000; REM -> 0.
- Writeback:
  - In DONE: wb_wrt_en=1 unless the latched rd_addr=0, in which case wb_wrt_en=0 but done=1.
  - wb_wrt_addr and wb_wrt_data hold their values from DONE until the next DONE.
- start while busy is ignored; no queueing.
- Simultaneous start and kill in IDLE: kill wins, nothing accepted.
- kill=1 in CALC or DONE: next state IDLE. Suppresses done and wb_wrt_en in that cycle (combinational gating in DONE). busy drops the next cycle.
- Reset asserted mid-op: immediate return to IDLE with all outputs 0; the op is lost.

Optional Feature:
- Macro MULDIV_FAST_MUL_EN.
- When defined: the four multiply ops use a single-cycle full 64-bit multiplier. Accepted multiply goes IDLE -> DONE, with done in the cycle after edge 1. Divide ops are unchanged.
- When undefined: multiply uses the iterative 32-cycle path and no hardware multiplier is inferred.
- Results are bit-identical either way.

Test Plan:
- MUL 7 x -3 (rs2=0xFFFFFFFD), rd=5 -> one done pulse after edge 33; wb_wrt_en=1, addr=5, data=0xFFFFFFEB; busy high for 33 cycles.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIV 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, each with done after edge 1. DIV 0x80000000/-1 -> 0x80000000; REM -> 0.
- kill at CALC cycle 10 -> no done, no wb_wrt_en; busy low the next cycle. A new start is then accepted normally.
- rd=0 MUL 3x4 -> done=1, wb_wrt_en=0. start pulses while busy are ignored. Async reset mid-CALC -> outputs 0 immediately.
